// File: rtl/rhs_trunc_accum_if.sv
// Handshake and result bus of the truncating accumulator stage.
// The master side (producer/consumer environment) drives the sample and
// out_ready. The slave side (the stage itself) drives in_ready and the
// result slot.
interface rhs_trunc_accum_if #(
  parameter int W  = 3,
  parameter int DW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_trunc;
  logic          out_lost;
  logic [W:0]    out_acc;
  logic          out_wrap;
  logic [3:0]    wrap_cnt;

  modport master (
    output in_valid, in_data, acc_clr, out_ready,
    input  in_ready, out_valid, out_trunc, out_lost, out_acc, out_wrap, wrap_cnt
  );

  modport slave (
    input  in_valid, in_data, acc_clr, out_ready,
    output in_ready, out_valid, out_trunc, out_lost, out_acc, out_wrap, wrap_cnt
  );
endinterface

// File: rtl/rhs_trunc_accum.sv
// Truncating accumulator stage: takes d, forms W'(d+1), flags nonzero bits
// lost by the cast, and adds the cast value into a wrapping (W+1)-bit sum.
// The result is held in a single registered output slot (1-cycle latency).
module rhs_trunc_accum #(
  parameter int W  = 3,
  parameter int DW = 6
) (
  input logic              clk,
  input logic              rst,
  rhs_trunc_accum_if.slave bus
);

  logic          r_out_valid;
  logic [W-1:0]  r_out_trunc;
  logic          r_out_lost;
  logic [W:0]    r_out_acc;
  logic          r_out_wrap;
  logic [3:0]    r_wrap_cnt;
  logic [W:0]    r_acc;

  logic          w_in_ready;
  logic          w_accept;
  logic [DW:0]   w_sum;
  logic [W-1:0]  w_trunc;
  logic          w_lost;
  logic [W:0]    w_base;
  logic [W+1:0]  w_full;

  // The slot can take a sample when empty or when it is being drained in the
  // same cycle; in_valid never feeds back into in_ready.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // d+1 is formed one bit wider than d so the all-ones sample reaches 2^DW
  // before the cast instead of wrapping to 0.
  assign w_sum   = {1'b0, bus.in_data} + {{DW{1'b0}}, 1'b1};
  assign w_trunc = w_sum[W-1:0];
  assign w_lost  = |w_sum[DW:W];

  // acc_clr only matters with an accepted sample; the carry out of bit W is
  // kept in the extra top bit of w_full and reported as the wrap flag.
  assign w_base = bus.acc_clr ? '0 : r_acc;
  assign w_full = {1'b0, w_base} + {2'b00, w_trunc};

  // Accumulator, saturating wrap counter and the output slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order in this block.
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_trunc <= '0;
      r_out_lost  <= 1'b0;
      r_out_acc   <= '0;
      r_out_wrap  <= 1'b0;
      r_wrap_cnt  <= '0;
      r_acc       <= '0;
    end else if (w_accept) begin
      r_acc       <= w_full[W:0];
      r_out_valid <= 1'b1;
      r_out_trunc <= w_trunc;
      r_out_lost  <= w_lost;
      r_out_acc   <= w_full[W:0];
      r_out_wrap  <= w_full[W+1];
      if (w_full[W+1] && (r_wrap_cnt != 4'hF)) begin
        r_wrap_cnt <= r_wrap_cnt + 4'd1;
      end
    end else if (bus.out_ready) begin
      // Drain without refill: only the valid flag drops, data fields hold.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_trunc = r_out_trunc;
  assign bus.out_lost  = r_out_lost;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_wrap  = r_out_wrap;
  assign bus.wrap_cnt  = r_wrap_cnt;

endmodule

// File: tb/tb_rhs_trunc_accum.sv
// Self-checking bench for rhs_trunc_accum (W=3, DW=6). A behavioural model
// computes cast, loss, accumulation and the slot occupancy with plain integer
// arithmetic; each test task compares the DUT against it or against constants.
module tb_rhs_trunc_accum;

  localparam int W  = 3;
  localparam int DW = 6;
  localparam int VW = 2 * W + 8;  // {valid, trunc, lost, acc, wrap, wrap_cnt}

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int            m_acc;
  int            m_wcnt;
  bit            m_valid;
  logic [VW-1:0] m_vec;
  bit            m_ready_pre;  // model's in_ready before the last edge
  logic          o_ready_pre;  // DUT's in_ready before the last edge

  rhs_trunc_accum_if #(.W(W), .DW(DW)) bus ();

  rhs_trunc_accum #(.W(W), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs_vec();
    return {bus.out_valid, bus.out_trunc, bus.out_lost, bus.out_acc,
            bus.out_wrap, bus.wrap_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one sample in the model using integer arithmetic on the rules.
  task automatic model_step(input int d, input bit clr);
    int s, tr, base, full;
    bit lost, wr;
    s    = d + 1;
    tr   = s % (2 ** W);
    lost = (s >= (2 ** W));
    base = clr ? 0 : m_acc;
    full = base + tr;
    m_acc = full % (2 ** (W + 1));
    wr    = (full >= (2 ** (W + 1)));
    if (wr && m_wcnt < 15) m_wcnt++;
    m_valid = 1'b1;
    m_vec   = {1'b1, W'(tr), lost, (W+1)'(m_acc), wr, 4'(m_wcnt)};
  endtask

  // Drive one cycle of stimulus and advance the model by the handshake rules.
  task automatic cycle(input bit valid, input int d, input bit clr, input bit ready);
    bus.in_valid  = valid;
    bus.in_data   = DW'(d);
    bus.acc_clr   = clr;
    bus.out_ready = ready;
    #1;
    o_ready_pre = bus.in_ready;
    m_ready_pre = !m_valid || ready;
    tick();
    if (valid && m_ready_pre) model_step(d, clr);
    else if (m_valid && ready) m_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    rst     = 1'b0;
    m_acc   = 0;
    m_wcnt  = 0;
    m_valid = 1'b0;
    m_vec   = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs_vec(), {VW{1'b0}});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic_cast();
    cycle(1, 5, 0, 1);
    checks++;
    if (obs_vec() !== {1'b1, 3'd6, 1'b0, 4'd6, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL basic_cast: got %h expected %h", obs_vec(),
               {1'b1, 3'd6, 1'b0, 4'd6, 1'b0, 4'd0});
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: out_valid got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_truncation();
    int  ds[3]  = '{7, 63, 6};
    int  tr[3]  = '{0, 0, 7};
    bit  ls[3]  = '{1, 1, 0};
    foreach (ds[i]) begin
      cycle(1, ds[i], 0, 1);
      checks++;
      if (bus.out_trunc !== W'(tr[i]) || bus.out_lost !== ls[i]) begin
        errors++;
        $display("FAIL trunc_d%0d: got trunc=%0d lost=%b expected trunc=%0d lost=%b",
                 ds[i], bus.out_trunc, bus.out_lost, tr[i], ls[i]);
      end
      checks++;
      if (obs_vec() !== m_vec) begin
        errors++;
        $display("FAIL trunc_model_d%0d: got %h expected %h", ds[i], obs_vec(), m_vec);
      end
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_back_to_back_wrap();
    int accs[3]  = '{6, 12, 2};
    bit wraps[3] = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      cycle(1, 5, (i == 0), 1);
      checks++;
      if (o_ready_pre !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready_%0d: got %b expected 1", i, o_ready_pre);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_acc !== 4'(accs[i]) ||
          bus.out_wrap !== wraps[i]) begin
        errors++;
        $display("FAIL b2b_acc_%0d: got v=%b acc=%0d wrap=%b expected v=1 acc=%0d wrap=%b",
                 i, bus.out_valid, bus.out_acc, bus.out_wrap, accs[i], wraps[i]);
      end
    end
    checks++;
    if (bus.wrap_cnt !== 4'd1) begin
      errors++;
      $display("FAIL b2b_wrap_cnt: got %0d expected 1", bus.wrap_cnt);
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] held;
    cycle(1, 1, 0, 1);
    held = m_vec;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 2, 0, 0);
      checks++;
      if (o_ready_pre !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready_%0d: got %b expected 0", i, o_ready_pre);
      end
      checks++;
      if (obs_vec() !== held) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, obs_vec(), held);
      end
    end
    // Raising out_ready lets the waiting sample in on the draining edge.
    cycle(1, 2, 0, 1);
    checks++;
    if (o_ready_pre !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b expected 1", o_ready_pre);
    end
    checks++;
    if (obs_vec() !== m_vec || bus.out_trunc !== 3'd3) begin
      errors++;
      $display("FAIL release_reload: got %h expected %h", obs_vec(), m_vec);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_drain: out_valid got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_acc_clr();
    cycle(1, 5, 1, 1);
    cycle(1, 5, 0, 1);
    checks++;
    if (bus.out_acc !== 4'd12) begin
      errors++;
      $display("FAIL clr_setup: acc got %0d expected 12", bus.out_acc);
    end
    cycle(1, 2, 1, 1);
    checks++;
    if (bus.out_acc !== 4'd3 || bus.out_wrap !== 1'b0 || bus.out_trunc !== 3'd3) begin
      errors++;
      $display("FAIL clr_accept: got acc=%0d wrap=%b trunc=%0d expected acc=3 wrap=0 trunc=3",
               bus.out_acc, bus.out_wrap, bus.out_trunc);
    end
    // acc_clr while stalled is not an accept and must leave the sum alone.
    cycle(1, 9, 1, 0);
    cycle(1, 0, 0, 1);
    checks++;
    if (bus.out_acc !== 4'd4 || obs_vec() !== m_vec) begin
      errors++;
      $display("FAIL clr_ignored: got acc=%0d vec=%h expected acc=4 vec=%h",
               bus.out_acc, obs_vec(), m_vec);
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_saturation();
    int wraps = 0;
    for (int i = 0; i < 100 && wraps < 20; i++) begin
      cycle(1, 6, 0, 1);
      if (m_vec[4]) wraps++;
      checks++;
      if (obs_vec() !== m_vec) begin
        errors++;
        $display("FAIL sat_step_%0d: got %h expected %h", i, obs_vec(), m_vec);
      end
    end
    checks++;
    if (wraps != 20 || bus.wrap_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_wrap_cnt: got %0d after %0d wraps expected 15 after 20",
               bus.wrap_cnt, wraps);
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, $urandom_range(0, 2 ** DW - 1),
            ($urandom % 8) == 0, ($urandom % 3) != 0);
      checks++;
      if (o_ready_pre !== m_ready_pre) begin
        errors++;
        $display("FAIL rand_in_ready_%0d: got %b expected %b", i, o_ready_pre, m_ready_pre);
      end
      checks++;
      if (m_valid ? (obs_vec() !== m_vec)
                  : ({bus.out_valid, bus.wrap_cnt} !== {1'b0, 4'(m_wcnt)})) begin
        errors++;
        $display("FAIL rand_out_%0d: got %h expected %h (valid=%b)", i, obs_vec(), m_vec, m_valid);
      end
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_stall();
    cycle(1, 3, 0, 1);
    cycle(1, 4, 0, 0);
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    m_acc   = 0;
    m_wcnt  = 0;
    m_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_acc !== 4'd0 || bus.wrap_cnt !== 4'd0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_stall: got v=%b acc=%0d wcnt=%0d rdy=%b expected v=0 acc=0 wcnt=0 rdy=1",
               bus.out_valid, bus.out_acc, bus.wrap_cnt, bus.in_ready);
    end
    cycle(1, 1, 0, 1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_acc !== 4'd2) begin
      errors++;
      $display("FAIL rst_restart: got v=%b acc=%0d expected v=1 acc=2",
               bus.out_valid, bus.out_acc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_cast();
    test_truncation();
    test_back_to_back_wrap();
    test_backpressure();
    test_acc_clr();
    test_saturation();
    test_random();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
